// File: rtl/zap_tlb_walk_ctrl.sv
// zap_tlb_walk_ctrl: page-table walk sequencer for the ZAP MMU.
//
// Fetches the L1 descriptor and, when it points to a coarse or fine table,
// the L2 descriptor. Only one memory read is outstanding at a time. A walk
// ends with exactly one TLB refill strobe or one fault pulse.
//
// Ports
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_walk, i_va            walk request (level) and missing VA
//   i_baddr                 translation table base ([31:14] used)
//   i_abort                 cancel current walk
//   o_mem_stb/o_mem_addr    descriptor read request, held until i_mem_ack
//   i_mem_ack/_rdata/_err   read completion
//   o_{se,sp,lp,fp}tlb_wen  one-cycle refill strobes (section/small/large/tiny)
//   o_desc/_dac/_va         descriptor, domain and VA for the refill
//   o_fault/o_fsr/o_far     one-cycle fault pulse with {domain,status} and VA
//   o_busy                  high in every state except IDLE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for i_walk (ignored in the first cycle after a walk)
// L1_FETCH | L1 descriptor read outstanding
// L2_FETCH | stb low for one cycle after L1 ack, then L2 read outstanding
// REFILL   | one refill strobe
// FAULT    | one fault pulse
// DRAIN    | aborted walk, waiting for the outstanding ack to discard it

module zap_tlb_walk_ctrl #(
  parameter int PHY_ADDR_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_walk,
  input  logic [31:0]           i_va,
  input  logic [31:0]           i_baddr,
  input  logic                  i_abort,
  output logic                  o_mem_stb,
  output logic [PHY_ADDR_W-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [31:0]           i_mem_rdata,
  input  logic                  i_mem_err,
  output logic                  o_setlb_wen,
  output logic                  o_sptlb_wen,
  output logic                  o_lptlb_wen,
  output logic                  o_fptlb_wen,
  output logic [31:0]           o_desc,
  output logic [3:0]            o_desc_dac,
  output logic [31:0]           o_desc_va,
  output logic                  o_fault,
  output logic [7:0]            o_fsr,
  output logic [31:0]           o_far,
  output logic                  o_busy
);

  typedef enum logic [2:0] {IDLE, L1_FETCH, L2_FETCH, REFILL, FAULT, DRAIN} state_t;

  localparam logic [1:0] K_SEC   = 2'd0;
  localparam logic [1:0] K_LARGE = 2'd1;
  localparam logic [1:0] K_SMALL = 2'd2;
  localparam logic [1:0] K_TINY  = 2'd3;

  localparam logic [3:0] ST_L1_EXT  = 4'b1100;
  localparam logic [3:0] ST_SECTION = 4'b0101;
  localparam logic [3:0] ST_L2_EXT  = 4'b1110;
  localparam logic [3:0] ST_PAGE    = 4'b0111;

  state_t                state_q, state_d;
  logic                  stb_q, stb_d;
  logic                  ret_q;
  logic [PHY_ADDR_W-1:0] addr_q;
  logic [31:0]           va_q;
  logic [31:0]           desc_q;
  logic [3:0]            dac_q;
  logic [7:0]            fsr_q;
  logic [1:0]            kind_q;
  logic                  fine_q;
  logic                  ack_v;
  logic                  l2_bad;
  logic                  unused_baddr;

  assign unused_baddr = ^i_baddr[13:0];

  // An ack only counts while our request is actually on the bus.
  assign ack_v  = stb_q & i_mem_ack;
  // Tiny pages only exist in fine tables.
  assign l2_bad = i_mem_err || (i_mem_rdata[1:0] == 2'b00) ||
                  ((i_mem_rdata[1:0] == 2'b11) && !fine_q);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      ret_q   <= (state_q != IDLE) && (state_d == IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    case (state_q)
      IDLE: begin
        if (i_walk && !i_abort && !ret_q) begin
          state_d = L1_FETCH;
          stb_d   = 1'b1;
        end
      end
      L1_FETCH: begin
        if (ack_v) begin
          stb_d = 1'b0;
          if (i_abort)                                     state_d = IDLE;
          else if (i_mem_err || i_mem_rdata[1:0] == 2'b00) state_d = FAULT;
          else if (i_mem_rdata[1:0] == 2'b10)              state_d = REFILL;
          else                                             state_d = L2_FETCH;
        end else if (i_abort) begin
          state_d = DRAIN;
        end
      end
      L2_FETCH: begin
        if (!stb_q) begin
          // Gap cycle: nothing outstanding yet, so an abort can leave directly.
          if (i_abort) state_d = IDLE;
          else         stb_d   = 1'b1;
        end else if (ack_v) begin
          stb_d = 1'b0;
          if (i_abort)     state_d = IDLE;
          else if (l2_bad) state_d = FAULT;
          else             state_d = REFILL;
        end else if (i_abort) begin
          state_d = DRAIN;
        end
      end
      REFILL, FAULT: state_d = IDLE;
      DRAIN: begin
        if (ack_v) begin
          stb_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr_q <= '0;
      va_q   <= '0;
      desc_q <= '0;
      dac_q  <= '0;
      fsr_q  <= '0;
      kind_q <= K_SEC;
      fine_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (state_d == L1_FETCH) begin
            va_q   <= i_va;
            addr_q <= {i_baddr[31:14], i_va[31:20], 2'b00};
          end
        end
        L1_FETCH: begin
          if (ack_v && !i_abort) begin
            if (i_mem_err) begin
              fsr_q <= {4'h0, ST_L1_EXT};
            end else begin
              case (i_mem_rdata[1:0])
                2'b00: fsr_q <= {4'h0, ST_SECTION};
                2'b10: begin
                  desc_q <= i_mem_rdata;
                  dac_q  <= i_mem_rdata[8:5];
                  kind_q <= K_SEC;
                end
                2'b01: begin
                  dac_q  <= i_mem_rdata[8:5];
                  fine_q <= 1'b0;
                  addr_q <= {i_mem_rdata[31:10], va_q[19:12], 2'b00};
                end
                default: begin
                  dac_q  <= i_mem_rdata[8:5];
                  fine_q <= 1'b1;
                  addr_q <= {i_mem_rdata[31:12], va_q[19:10], 2'b00};
                end
              endcase
            end
          end
        end
        L2_FETCH: begin
          if (ack_v && !i_abort) begin
            if (i_mem_err) begin
              fsr_q <= {dac_q, ST_L2_EXT};
            end else if (l2_bad) begin
              fsr_q <= {dac_q, ST_PAGE};
            end else begin
              desc_q <= i_mem_rdata;
              case (i_mem_rdata[1:0])
                2'b01:   kind_q <= K_LARGE;
                2'b10:   kind_q <= K_SMALL;
                default: kind_q <= K_TINY;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_setlb_wen = 1'b0;
    o_sptlb_wen = 1'b0;
    o_lptlb_wen = 1'b0;
    o_fptlb_wen = 1'b0;
    o_fault     = 1'b0;
    o_busy      = (state_q != IDLE);
    if (state_q == REFILL && !i_abort) begin
      case (kind_q)
        K_SEC:   o_setlb_wen = 1'b1;
        K_LARGE: o_lptlb_wen = 1'b1;
        K_SMALL: o_sptlb_wen = 1'b1;
        default: o_fptlb_wen = 1'b1;
      endcase
    end
    if (state_q == FAULT && !i_abort) o_fault = 1'b1;
  end

  assign o_mem_stb  = stb_q;
  assign o_mem_addr = addr_q;
  assign o_desc     = desc_q;
  assign o_desc_dac = dac_q;
  assign o_desc_va  = va_q;
  assign o_fsr      = fsr_q;
  assign o_far      = va_q;

endmodule

// File: tb/tb_zap_tlb_walk_ctrl.sv
// Self-checking bench for zap_tlb_walk_ctrl. Scenario tasks drive walks and
// check timing inline; expected refills/faults are queued when a walk is
// launched and popped by a monitor whenever the DUT raises a strobe.
module tb_zap_tlb_walk_ctrl;
  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_walk = 1'b0;
  logic [31:0] i_va = '0;
  logic [31:0] i_baddr = 32'h0000_4000;
  logic        i_abort = 1'b0;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        i_mem_err = 1'b0;
  logic        o_mem_stb;
  logic [31:0] o_mem_addr;
  logic        o_setlb_wen, o_sptlb_wen, o_lptlb_wen, o_fptlb_wen;
  logic [31:0] o_desc;
  logic [3:0]  o_desc_dac;
  logic [31:0] o_desc_va;
  logic        o_fault;
  logic [7:0]  o_fsr;
  logic [31:0] o_far;
  logic        o_busy;

  zap_tlb_walk_ctrl #(.PHY_ADDR_W(32)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_walk(i_walk), .i_va(i_va),
    .i_baddr(i_baddr), .i_abort(i_abort), .o_mem_stb(o_mem_stb),
    .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .i_mem_err(i_mem_err), .o_setlb_wen(o_setlb_wen), .o_sptlb_wen(o_sptlb_wen),
    .o_lptlb_wen(o_lptlb_wen), .o_fptlb_wen(o_fptlb_wen), .o_desc(o_desc),
    .o_desc_dac(o_desc_dac), .o_desc_va(o_desc_va), .o_fault(o_fault),
    .o_fsr(o_fsr), .o_far(o_far), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // kind: 0 section, 1 large, 2 small, 3 tiny, 4 fault
  typedef struct {
    int          kind;
    logic [31:0] desc;
    logic [3:0]  dac;
    logic [31:0] va;
    logic [7:0]  fsr;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  exp_t m_e;
  int   m_kind;
  int   m_act;

  always @(negedge i_clk) begin
    if (i_reset_n) begin
      m_act = $countones({o_setlb_wen, o_sptlb_wen, o_lptlb_wen, o_fptlb_wen, o_fault});
      if (m_act != 0) begin
        m_kind = o_fault ? 4 : o_setlb_wen ? 0 : o_lptlb_wen ? 1 : o_sptlb_wen ? 2 : 3;
        n_cmp++;
        if (m_act != 1) begin n_bad++; $display("FAIL one_hot: %0d strobes active, required 1", m_act); end
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL sb_unexpected: event kind %0d at %0t, required none", m_kind, $time);
        end else begin
          m_e = sb.pop_front();
          if (m_kind != m_e.kind) begin n_bad++; $display("FAIL sb_kind: got %0d required %0d", m_kind, m_e.kind); end
          if (m_e.kind == 4) begin
            n_cmp++;
            if (o_fsr !== m_e.fsr) begin n_bad++; $display("FAIL sb_fsr: got %h required %h", o_fsr, m_e.fsr); end
            n_cmp++;
            if (o_far !== m_e.va) begin n_bad++; $display("FAIL sb_far: got %h required %h", o_far, m_e.va); end
          end else begin
            n_cmp++;
            if (o_desc !== m_e.desc) begin n_bad++; $display("FAIL sb_desc: got %h required %h", o_desc, m_e.desc); end
            n_cmp++;
            if (o_desc_dac !== m_e.dac) begin n_bad++; $display("FAIL sb_dac: got %h required %h", o_desc_dac, m_e.dac); end
            n_cmp++;
            if (o_desc_va !== m_e.va) begin n_bad++; $display("FAIL sb_va: got %h required %h", o_desc_va, m_e.va); end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic start_walk(input logic [31:0] va);
    i_va = va; i_walk = 1'b1; tick(); i_walk = 1'b0;
  endtask

  task automatic ack(input logic [31:0] d, input logic e);
    i_mem_rdata = d; i_mem_err = e; i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0; i_mem_err = 1'b0;
  endtask

  task automatic push_refill(input int k, input logic [31:0] d, input logic [3:0] dac, input logic [31:0] va);
    exp_t e;
    e.kind = k; e.desc = d; e.dac = dac; e.va = va; e.fsr = '0;
    sb.push_back(e);
  endtask

  task automatic push_fault(input logic [7:0] fsr, input logic [31:0] va);
    exp_t e;
    e.kind = 4; e.desc = '0; e.dac = '0; e.va = va; e.fsr = fsr;
    sb.push_back(e);
  endtask

  // Waits (bounded) for IDLE, then spends the return cycle.
  task automatic idle_wait();
    int n;
    n = 0;
    while (o_busy && n < 20) begin tick(); n++; end
    n_cmp++;
    if (o_busy !== 1'b0) begin n_bad++; $display("FAIL idle_timeout: o_busy=%b after %0d cycles, required 0", o_busy, n); end
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge i_clk);
    #1;
    n_cmp++; if (o_mem_stb !== 1'b0) begin n_bad++; $display("FAIL rst_stb: got %b required 0", o_mem_stb); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", o_busy); end
    n_cmp++; if (o_mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h required 0", o_mem_addr); end
    n_cmp++; if ({o_setlb_wen, o_sptlb_wen, o_lptlb_wen, o_fptlb_wen, o_fault} !== 5'b0) begin
      n_bad++; $display("FAIL rst_strobes: got %b required 00000", {o_setlb_wen, o_sptlb_wen, o_lptlb_wen, o_fptlb_wen, o_fault}); end
    n_cmp++; if ({o_desc, o_desc_dac, o_desc_va, o_fsr, o_far} !== 108'h0) begin
      n_bad++; $display("FAIL rst_data: desc=%h dac=%h va=%h fsr=%h far=%h required all 0", o_desc, o_desc_dac, o_desc_va, o_fsr, o_far); end
    i_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_section();
    start_walk(32'h1234_5678);
    n_cmp++; if (o_mem_stb !== 1'b1) begin n_bad++; $display("FAIL sec_stb: got %b required 1", o_mem_stb); end
    n_cmp++; if (o_mem_addr !== 32'h0000_448C) begin n_bad++; $display("FAIL sec_addr: got %h required 0000448c", o_mem_addr); end
    push_refill(0, 32'h8000_0C2A, 4'd1, 32'h1234_5678);
    ack(32'h8000_0C2A, 1'b0);
    n_cmp++; if (o_setlb_wen !== 1'b1) begin n_bad++; $display("FAIL sec_wen_cycle2: got %b required 1", o_setlb_wen); end
    n_cmp++; if (o_mem_stb !== 1'b0) begin n_bad++; $display("FAIL sec_stb_drop: got %b required 0", o_mem_stb); end
    tick();
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL sec_idle: got %b required 0", o_busy); end
    idle_wait();
  endtask

  task automatic test_back_to_back();
    i_va = 32'h0FF0_0000; i_walk = 1'b1;
    tick();
    n_cmp++; if (o_mem_addr !== 32'h0000_43FC) begin n_bad++; $display("FAIL b2b_addr: got %h required 000043fc", o_mem_addr); end
    push_refill(0, 32'hFFF0_01E2, 4'hF, 32'h0FF0_0000);
    ack(32'hFFF0_01E2, 1'b0);
    tick();
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_ret_cycle: got busy %b required 0", o_busy); end
    tick();
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_ignore: got busy %b required 0", o_busy); end
    tick();
    n_cmp++; if (o_mem_stb !== 1'b1) begin n_bad++; $display("FAIL b2b_restart: got stb %b required 1", o_mem_stb); end
    i_walk = 1'b0;
    push_fault(8'h05, 32'h0FF0_0000);
    ack(32'h0, 1'b0);
    idle_wait();
  endtask

  task automatic test_coarse_small();
    start_walk(32'h1234_5678);
    ack(32'h0010_0021, 1'b0);
    n_cmp++; if (o_mem_stb !== 1'b0 || o_busy !== 1'b1) begin n_bad++; $display("FAIL cs_gap: got stb %b busy %b required 0 1", o_mem_stb, o_busy); end
    tick();
    n_cmp++; if (o_mem_stb !== 1'b1) begin n_bad++; $display("FAIL cs_l2_stb: got %b required 1", o_mem_stb); end
    n_cmp++; if (o_mem_addr !== 32'h0010_0114) begin n_bad++; $display("FAIL cs_l2_addr: got %h required 00100114", o_mem_addr); end
    push_refill(2, 32'h9000_0FFE, 4'd1, 32'h1234_5678);
    ack(32'h9000_0FFE, 1'b0);
    n_cmp++; if ({o_setlb_wen, o_sptlb_wen, o_lptlb_wen, o_fptlb_wen} !== 4'b0100) begin
      n_bad++; $display("FAIL cs_wen_cycle4: got %b required 0100", {o_setlb_wen, o_sptlb_wen, o_lptlb_wen, o_fptlb_wen}); end
    idle_wait();
  endtask

  task automatic test_l1_fault();
    push_fault(8'h05, 32'hABCD_E000);
    start_walk(32'hABCD_E000);
    ack(32'h0, 1'b0);
    n_cmp++; if (o_fault !== 1'b1 || o_fsr !== 8'h05) begin n_bad++; $display("FAIL l1f_pulse: got fault %b fsr %h required 1 05", o_fault, o_fsr); end
    n_cmp++; if (o_far !== 32'hABCD_E000) begin n_bad++; $display("FAIL l1f_far: got %h required abcde000", o_far); end
    idle_wait();
    push_fault(8'h0C, 32'h0000_1000);
    start_walk(32'h0000_1000);
    ack(32'h8000_0C2A, 1'b1);
    idle_wait();
  endtask

  task automatic test_l2_err();
    start_walk(32'h1234_5678);
    ack(32'h0020_0033, 1'b0);
    tick();
    n_cmp++; if (o_mem_addr !== 32'h0020_0454) begin n_bad++; $display("FAIL l2e_addr: got %h required 00200454", o_mem_addr); end
    push_fault(8'h1E, 32'h1234_5678);
    ack(32'h0000_0002, 1'b1);
    n_cmp++; if (o_fault !== 1'b1 || o_fsr !== 8'h1E) begin n_bad++; $display("FAIL l2e_pulse: got fault %b fsr %h required 1 1e", o_fault, o_fsr); end
    idle_wait();
  endtask

  task automatic test_l2_kinds();
    logic [31:0] l1s [4];
    logic [31:0] l2s [4];
    int          knd [4];
    logic [3:0]  dms [4];
    l1s = '{32'h0010_0021, 32'h0020_0033, 32'h0020_01F3, 32'h0010_0041};
    l2s = '{32'h1234_5001, 32'h5555_0003, 32'h0000_1002, 32'h0000_0000};
    knd = '{1, 3, 2, 4};
    dms = '{4'd1, 4'd1, 4'hF, 4'd2};
    for (int i = 0; i < 4; i++) begin
      if (knd[i] == 4) push_fault({dms[i], 4'b0111}, 32'h0765_4321);
      else             push_refill(knd[i], l2s[i], dms[i], 32'h0765_4321);
      start_walk(32'h0765_4321);
      ack(l1s[i], 1'b0);
      tick();
      ack(l2s[i], 1'b0);
      idle_wait();
    end
  endtask

  task automatic test_abort();
    start_walk(32'h1234_5678);
    tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    n_cmp++; if (o_mem_stb !== 1'b1 || o_busy !== 1'b1) begin n_bad++; $display("FAIL ab_drain: got stb %b busy %b required 1 1", o_mem_stb, o_busy); end
    tick();
    n_cmp++; if (o_mem_addr !== 32'h0000_448C || o_mem_stb !== 1'b1) begin n_bad++; $display("FAIL ab_hold: got stb %b addr %h required 1 0000448c", o_mem_stb, o_mem_addr); end
    tick();
    ack(32'h8000_0C2A, 1'b0);
    n_cmp++; if (o_busy !== 1'b0 || o_mem_stb !== 1'b0) begin n_bad++; $display("FAIL ab_done: got busy %b stb %b required 0 0", o_busy, o_mem_stb); end
    idle_wait();
    start_walk(32'h1234_5678);
    n_cmp++; if (o_mem_stb !== 1'b1) begin n_bad++; $display("FAIL ab_next_walk: got stb %b required 1", o_mem_stb); end
    push_refill(0, 32'h8000_0C2A, 4'd1, 32'h1234_5678);
    ack(32'h8000_0C2A, 1'b0);
    idle_wait();
  endtask

  task automatic test_abort_edges();
    start_walk(32'h2000_0000);
    i_abort = 1'b1;
    ack(32'h8000_0C2A, 1'b0);
    i_abort = 1'b0;
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL abk_idle: got busy %b required 0", o_busy); end
    idle_wait();
    start_walk(32'h2000_0000);
    ack(32'h8000_0C2A, 1'b0);
    i_abort = 1'b1;
    #1;
    n_cmp++; if (o_setlb_wen !== 1'b0) begin n_bad++; $display("FAIL abr_suppress: got wen %b required 0", o_setlb_wen); end
    tick();
    i_abort = 1'b0;
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL abr_idle: got busy %b required 0", o_busy); end
    idle_wait();
  endtask

  task automatic test_tiny_coarse_reset();
    push_fault(8'h17, 32'h1234_5678);
    start_walk(32'h1234_5678);
    ack(32'h0010_0021, 1'b0);
    tick();
    ack(32'h0000_0003, 1'b0);
    n_cmp++; if (o_fault !== 1'b1 || o_fsr !== 8'h17) begin n_bad++; $display("FAIL tc_fault: got fault %b fsr %h required 1 17", o_fault, o_fsr); end
    idle_wait();
    start_walk(32'h1234_5678);
    ack(32'h0010_0021, 1'b0);
    tick();
    n_cmp++; if (o_mem_stb !== 1'b1) begin n_bad++; $display("FAIL tc_l2_stb: got %b required 1", o_mem_stb); end
    #2 i_reset_n = 1'b0;
    #1;
    n_cmp++; if (o_mem_stb !== 1'b0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL tc_rst_ctrl: got stb %b busy %b required 0 0", o_mem_stb, o_busy); end
    n_cmp++; if ({o_mem_addr, o_desc, o_desc_dac, o_desc_va, o_fsr, o_far} !== 140'h0) begin
      n_bad++; $display("FAIL tc_rst_data: addr=%h desc=%h dac=%h va=%h fsr=%h far=%h required all 0", o_mem_addr, o_desc, o_desc_dac, o_desc_va, o_fsr, o_far); end
    tick();
    i_reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_section();
    test_back_to_back();
    test_coarse_small();
    test_l1_fault();
    test_l2_err();
    test_l2_kinds();
    test_abort();
    test_abort_edges();
    test_tiny_coarse_reset();
    repeat (3) tick();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover: %0d expected events never seen, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
